// File: rtl/bitstream_serializer.sv
// Serializes a session of parallel configuration words LSB-first onto one
// serial line, qualified by a per-target (SMU or SRU) stream valid.
module bitstream_serializer #(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              target,
  input  logic [LEN_W-1:0]  bitLen,
  input  logic [WORD_W-1:0] wordIn,
  input  logic              wordValid,
  output logic              wordReady,
  input  logic              abort,
  output logic              bitstreamSerialOut,
  output logic              smuStreamValid,
  output logic              sruStreamValid,
  output logic              busy,
  output logic              done,
  output logic [1:0]        stateDbg
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t            state;
  state_t            stateNext;
  logic              tgt;
  logic [LEN_W-1:0]  remaining;
  logic [CNT_W-1:0]  inCnt;
  logic [WORD_W-1:0] shiftReg;

  // Word handshake: a word transfers on any cycle where wordValid and
  // wordReady are both high at the rising edge. wordReady depends on state
  // only, so the producer may hold wordValid freely outside FETCH.
  assign wordReady = (state == FETCH);

  // Every output is a decode of registered state, target and shift register.
  assign busy               = (state != IDLE);
  assign done               = (state == DONE);
  assign bitstreamSerialOut = (state == SHIFT) & shiftReg[0];
  assign smuStreamValid     = (state == SHIFT) & ~tgt;
  assign sruStreamValid     = (state == SHIFT) & tgt;
  assign stateDbg           = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (start) stateNext = (bitLen == '0) ? DONE : FETCH;
      FETCH: if (wordValid) stateNext = SHIFT;
      SHIFT: if (inCnt == CNT_W'(1))
               stateNext = (remaining == LEN_W'(1)) ? DONE : FETCH;
      DONE:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    // Abort cancels any active session but never a start taken in IDLE.
    if (abort && state != IDLE) stateNext = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt       <= 1'b0;
      remaining <= '0;
      inCnt     <= '0;
      shiftReg  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          tgt       <= target;
          remaining <= bitLen;
        end
        FETCH: if (wordValid) begin
          shiftReg <= wordIn;
          // A short final word only emits its low `remaining` bits.
          if (32'(remaining) >= 32'(WORD_W)) inCnt <= CNT_W'(WORD_W);
          else                               inCnt <= CNT_W'(remaining);
        end
        SHIFT: begin
          shiftReg  <= shiftReg >> 1;
          inCnt     <= inCnt - CNT_W'(1);
          remaining <= remaining - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitstream_serializer.sv
// Scoreboard bench for bitstream_serializer: expected {target,bit} pairs are
// queued as words are driven and popped as the DUT emits qualified bits.
module tb_bitstream_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        target;
  logic [15:0] bitLen;
  logic [31:0] wordIn;
  logic        wordValid;
  logic        wordReady;
  logic        abort;
  logic        bitstreamSerialOut;
  logic        smuStreamValid;
  logic        sruStreamValid;
  logic        busy;
  logic        done;
  logic [1:0]  stateDbg;

  bitstream_serializer #(.WORD_W(32), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .target(target), .bitLen(bitLen),
    .wordIn(wordIn), .wordValid(wordValid), .wordReady(wordReady),
    .abort(abort), .bitstreamSerialOut(bitstreamSerialOut),
    .smuStreamValid(smuStreamValid), .sruStreamValid(sruStreamValid),
    .busy(busy), .done(done), .stateDbg(stateDbg)
  );

  always #5 clk = ~clk;

  logic [1:0] exp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;
  int bits_sess = 0;
  int gap_cnt = 0;
  int last_gap = 0;
  int excl_viol = 0;
  int ready_idle_viol = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [1:0] e;
    if (smuStreamValid && sruStreamValid) excl_viol++;
    if (wordReady && !busy) ready_idle_viol++;
    if (done) done_cnt++;
    if (smuStreamValid || sruStreamValid) begin
      if (bits_sess > 0 && gap_cnt > 0) last_gap = gap_cnt;
      gap_cnt = 0;
      bits_sess++;
      if (exp_q.size() == 0) check("extra_bit", 32'({sruStreamValid, bitstreamSerialOut}), 32'hFF);
      else begin
        e = exp_q.pop_front();
        check("bit", 32'({sruStreamValid, bitstreamSerialOut}), 32'(e));
      end
    end else if (busy) gap_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_session(input logic tgt, input int len);
    bits_sess = 0;
    gap_cnt   = 0;
    last_gap  = 0;
    start = 1'b1; target = tgt; bitLen = 16'(len);
    tick();
    start = 1'b0;
  endtask

  // Waits for FETCH (bounded), idles `delay` cycles, then presents one word.
  task automatic send_word(input logic [31:0] w, input logic tgt, input int npush, input int delay);
    for (int i = 0; i < 200 && !wordReady; i++) tick();
    check("word_ready_wait", 32'(wordReady), 32'd1);
    repeat (delay) tick();
    for (int i = 0; i < npush; i++) exp_q.push_back({tgt, w[i]});
    wordIn = w; wordValid = 1'b1;
    tick();
    wordValid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) tick();
    check("done_seen", 32'(done), 32'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; target = 1'b0; bitLen = '0;
    wordIn = '0; wordValid = 1'b0; abort = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_outputs", 32'({busy, done, wordReady, smuStreamValid, sruStreamValid, bitstreamSerialOut}), 32'd0);
    tick();

    // SMU single word, latency and done timing
    start_session(1'b0, 8);
    send_word(32'h0000_00A5, 1'b0, 8, 0);
    check("latency_first_bit", 32'({smuStreamValid, sruStreamValid, bitstreamSerialOut}), 32'b101);
    repeat (7) tick();
    check("last_bit_valid", 32'(smuStreamValid), 32'd1);
    tick();
    check("done_after_last", 32'({done, smuStreamValid}), 32'b10);
    tick();
    check("done_one_cycle", 32'({done, busy}), 32'b00);
    check("smu_bits", 32'(bits_sess), 32'd8);

    // SRU two words with a delayed second word
    start_session(1'b1, 40);
    send_word(32'hDEAD_BEEF, 1'b1, 32, 0);
    send_word(32'h0000_00FF, 1'b1, 8, 3);
    wait_done(50);
    check("sru_bits", 32'(bits_sess), 32'd40);
    check("sru_gap", 32'(last_gap), 32'd4);

    // Zero length
    start_session(1'b0, 0);
    check("zero_done", 32'({done, wordReady}), 32'b10);
    tick();
    check("zero_idle", 32'(busy), 32'd0);

    // Abort during third bit of a 16-bit session
    start_session(1'b0, 16);
    send_word(32'h0000_1235, 1'b0, 3, 0);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", 32'({busy, smuStreamValid, sruStreamValid, done}), 32'd0);
    repeat (3) tick();
    check("abort_no_done", 32'(done_cnt), 32'd3);
    start_session(1'b1, 4);
    send_word(32'hFFFF_FFFB, 1'b1, 4, 0);
    wait_done(20);
    check("after_abort_bits", 32'(bits_sess), 32'd4);

    // Reset held two cycles during the fifth bit
    start_session(1'b0, 16);
    send_word(32'h0000_F0F0, 1'b0, 5, 0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_shift", 32'({busy, done, wordReady, smuStreamValid, sruStreamValid, bitstreamSerialOut}), 32'd0);
    tick();
    rst = 1'b0;
    start_session(1'b1, 8);
    send_word(32'h0000_003C, 1'b1, 8, 0);
    wait_done(20);
    check("after_rst_bits", 32'(bits_sess), 32'd8);

    // Protocol misuse: wordValid in IDLE, start while busy
    wordIn = 32'h1234_5678; wordValid = 1'b1;
    repeat (3) tick();
    check("ready_in_idle", 32'({wordReady, busy}), 32'd0);
    wordValid = 1'b0;
    start_session(1'b0, 8);
    send_word(32'h0000_0096, 1'b0, 8, 0);
    start = 1'b1; target = 1'b1; bitLen = 16'd3; wordValid = 1'b1;
    tick();
    start = 1'b0; wordValid = 1'b0;
    wait_done(20);
    check("misuse_bits", 32'(bits_sess), 32'd8);
    repeat (2) tick();
    check("misuse_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 4; i++) begin
      int n = $urandom_range(1, 31);
      logic [31:0] w = $urandom;
      logic t = 1'($urandom_range(0, 1));
      start_session(t, n);
      send_word(w, t, n, $urandom_range(0, 2));
      wait_done(60);
      check("rand_bits", 32'(bits_sess), 32'(n));
    end

    check("exclusive_valids", 32'(excl_viol), 32'd0);
    check("ready_only_fetch", 32'(ready_idle_viol), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'd10);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bitstream_serializer.md
BITSTREAM_SERIALIZER -- requirements
Module: bitstream_serializer

Interface
REQ-001 SHALL have parameter WORD_W, default 32, width of each parallel configuration word.
REQ-002 SHALL have parameter LEN_W, default 16, width of the session bit-length field.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  begins a session; sampled only in IDLE.
REQ-006 SHALL have port target  input  1  stream select, 0 = SMU and 1 = SRU; sampled with start.
REQ-007 SHALL have port bitLen  input  LEN_W  total bits in the session; sampled with start.
REQ-008 SHALL have port wordIn  input  WORD_W  next configuration word.
REQ-009 SHALL have port wordValid  input  1  wordIn is valid.
REQ-010 SHALL have port wordReady  output  1  block accepts wordIn this cycle.
REQ-011 SHALL have port abort  input  1  cancels the active session.
REQ-012 SHALL have port bitstreamSerialOut  output  1  serial configuration bit.
REQ-013 SHALL have port smuStreamValid  output  1  qualifies bitstreamSerialOut for the SMU.
REQ-014 SHALL have port sruStreamValid  output  1  qualifies bitstreamSerialOut for the SRU.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at session completion.

Function
REQ-017 SHALL implement the states IDLE, FETCH, SHIFT and DONE.
REQ-018 In IDLE with start=1, SHALL latch target and latch bitLen into a remaining counter (LEN_W bits); next state is DONE if bitLen=0, otherwise FETCH.
REQ-019 SHALL ignore start when not in IDLE, and SHALL ignore wordValid when not in FETCH.
REQ-020 SHALL drive wordReady=1 exactly when in FETCH, decoded from state only with no combinational path from wordValid.
REQ-021 In FETCH, on wordValid&wordReady, SHALL load wordIn into the shift register, load the in-word counter with min(WORD_W, remaining), and move to SHIFT on the next cycle.
REQ-022 In each SHIFT cycle SHALL:
  - drive bitstreamSerialOut = shift register bit 0 (LSB-first);
  - assert the valid of the latched target only;
  - shift right by one;
  - decrement both counters.
REQ-023 On the last in-word bit of a SHIFT cycle, next state SHALL be DONE if remaining becomes 0, otherwise FETCH.
REQ-024 For a partial final word, only the low `remaining` bits SHALL be emitted; the upper bits are discarded.
REQ-025 Outside SHIFT, bitstreamSerialOut, smuStreamValid and sruStreamValid SHALL all be 0.
REQ-026 smuStreamValid and sruStreamValid SHALL never be high in the same cycle.
REQ-027 Stream outputs SHALL be decoded from registers only (state, target, shift register).
REQ-028 Latency: with start at cycle t and wordValid high at t+1, the first bit SHALL appear at t+2.
REQ-029 Each inter-word FETCH SHALL insert at least one cycle with valid low; receivers qualify every bit by valid.
REQ-030 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-031 abort in any non-IDLE state SHALL force IDLE on the next cycle, with valids low from that cycle, no done pulse and busy=0; abort in IDLE SHALL have no effect.
REQ-032 If abort and start are both high in IDLE, start SHALL be taken.

Reset
REQ-033 rst=1 at a clock edge SHALL set state to IDLE and clear both counters, the shift register and the latched target.
REQ-034 While in reset, every output SHALL be 0 on the following cycle.
REQ-035 rst SHALL take priority over abort, start and wordValid, including mid-SHIFT.

Verification
REQ-036 Reset: rst held for 2 cycles during the 5th SHIFT bit -> the next cycle shows all outputs 0 and busy=0, and a new session then runs normally.
REQ-037 SMU session: target=0, bitLen=8, word 0x000000A5 -> smuStreamValid high for 8 consecutive cycles with serial 1,0,1,0,0,1,0,1, sruStreamValid always 0, and done high the cycle after the last bit.
REQ-038 SRU multi-word session: target=1, bitLen=40, words 0xDEADBEEF then 0x000000FF, with the second wordValid delayed 3 cycles -> 32 bits of 0xDEADBEEF LSB-first, a 4-cycle valid-low gap, then 8 ones; exactly 40 cycles with sruStreamValid high.
REQ-039 Zero length: start at t with bitLen=0 -> done high at t+1, wordReady never high, valids never high.
REQ-040 Abort: abort during the 3rd bit of a 16-bit session -> valids low from the next cycle, no done pulse, and a following start with bitLen=4 completes correctly.
REQ-041 Protocol misuse: start pulsed while busy, and wordValid held high in IDLE -> no effect on the session, wordReady stays 0 in IDLE, and the bit count is unchanged.
